// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// Latency: none (pure wiring); Byte_Ready is driven by the loader.
// Backpressure: a byte transfers only on a cycle with Byte_Valid & Byte_Ready.
// Signals: Byte_In (stream byte), Byte_Valid (source has a byte), Byte_Ready (loader takes it).
interface imem_loader_if;
    logic [7:0] Byte_In;
    logic       Byte_Valid;
    logic       Byte_Ready;

    modport master (output Byte_In, output Byte_Valid, input Byte_Ready);
    modport slave  (input Byte_In, input Byte_Valid, output Byte_Ready);
endinterface

// File: rtl/imem_loader.sv
// Programs the byte-addressed instruction RAM from a framed stream
// (count byte, 4*N data bytes MSB-first per word, XOR checksum byte)
// and holds the CPU in reset until a load finishes with a good checksum.
// Latency: RAM write strobe 1 cycle after each accepted data byte.
// Backpressure: Byte_Ready is high only while expecting count/data/checksum.
// Ports: Clk, Reset (async, active-high), Start (load pulse), bs (byte
// stream, slave side), Mem_We/Mem_Addr/Mem_Wdata (RAM write port),
// Word_Done/Last_Word (word progress), Cpu_Hold, Load_Done, Load_Err, Err_Code.
module imem_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int MAX_WORDS  = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    imem_loader_if.slave          bs,
    output logic                  Mem_We,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [7:0]            Mem_Wdata,
    output logic                  Word_Done,
    output logic [31:0]           Last_Word,
    output logic                  Cpu_Hold,
    output logic                  Load_Done,
    output logic                  Load_Err,
    output logic [1:0]            Err_Code
);

    // Counter reaches 4*MAX_WORDS without wrapping.
    localparam int CW = $clog2(4 * MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_csum;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_last;     // index of the final data byte (4N-1)
    logic [23:0]     r_asm;      // first three bytes of the word in flight
    logic            w_rdy;
    logic            w_accept;
    logic            w_cnt_bad;

    assign w_rdy         = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
    assign bs.Byte_Ready = w_rdy;
    assign w_accept      = bs.Byte_Valid & w_rdy;
    assign w_cnt_bad     = (bs.Byte_In == 8'd0) || (bs.Byte_In > 8'(MAX_WORDS));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_COUNT;
            S_COUNT: if (w_accept) w_next = w_cnt_bad ? S_ERROR : S_DATA;
            S_DATA:  if (w_accept && (r_cnt == r_last)) w_next = S_CHECK;
            S_CHECK: if (w_accept) w_next = (bs.Byte_In == r_csum) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR: if (Start) w_next = S_COUNT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Mem_We    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_Wdata <= 8'd0;
            Word_Done <= 1'b0;
            Last_Word <= 32'd0;
            Cpu_Hold  <= 1'b1;
            Load_Done <= 1'b0;
            Load_Err  <= 1'b0;
            Err_Code  <= 2'd0;
            r_csum    <= 8'd0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_asm     <= 24'd0;
        end else begin
            Mem_We    <= 1'b0;
            Word_Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_csum    <= 8'd0;
                    r_cnt     <= '0;
                    Load_Done <= 1'b0;
                    Load_Err  <= 1'b0;
                    Err_Code  <= 2'd0;
                    Cpu_Hold  <= 1'b1;
                end
                S_COUNT: if (w_accept) begin
                    if (w_cnt_bad) begin
                        Load_Err <= 1'b1;
                        Err_Code <= 2'd1;
                    end else begin
                        r_csum <= bs.Byte_In;
                        r_cnt  <= '0;
                        r_last <= {bs.Byte_In[CW-3:0], 2'b00} - CW'(1);
                    end
                end
                S_DATA: if (w_accept) begin
                    Mem_We    <= 1'b1;
                    Mem_Addr  <= r_cnt[ADDR_WIDTH-1:0];
                    Mem_Wdata <= bs.Byte_In;
                    r_csum    <= r_csum ^ bs.Byte_In;
                    r_cnt     <= r_cnt + CW'(1);
                    r_asm     <= {r_asm[15:0], bs.Byte_In};
                    // Fourth byte of a word: publish the word alongside its write.
                    if (r_cnt[1:0] == 2'd3) begin
                        Last_Word <= {r_asm, bs.Byte_In};
                        Word_Done <= 1'b1;
                    end
                end
                S_CHECK: if (w_accept) begin
                    if (bs.Byte_In == r_csum) begin
                        Load_Done <= 1'b1;
                        Cpu_Hold  <= 1'b0;
                    end else begin
                        Load_Err <= 1'b1;
                        Err_Code <= 2'd2;
                    end
                end
                S_DONE, S_ERROR: if (Start) begin
                    Load_Done <= 1'b0;
                    Load_Err  <= 1'b0;
                    Err_Code  <= 2'd0;
                    Cpu_Hold  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
